// File: rtl/seven_seg_scanner_pkg.sv
// seven_seg_scanner_pkg: segment patterns, anode selects and default refresh divider for the scanner
package seven_seg_scanner_pkg;
    localparam int DEFAULT_REFRESH_DIV = 100000;
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [3:0] AN_D0    = 4'b1110;
    localparam logic [3:0] AN_D1    = 4'b1101;
    localparam logic [3:0] AN_D2    = 4'b1011;
    localparam logic [3:0] AN_D3    = 4'b0111;
    localparam logic [3:0] AN_OFF   = 4'b1111;
    function automatic logic [3:0] an_sel(input logic [1:0] idx);
        return idx == 2'd0 ? AN_D0 : idx == 2'd1 ? AN_D1 : idx == 2'd2 ? AN_D2 : AN_D3;
    endfunction
endpackage

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: digit inputs and display pin outputs of the scanner
interface seven_seg_scanner_if;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    modport master (output en, digits, dp_in, input seg, dp, an);
    modport slave  (input en, digits, dp_in, output seg, dp, an);
endinterface

// File: rtl/seven_seg_scanner_bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD to active-low {g..a} pattern, codes 10-15 shown as a dash
module bcd_to_7seg
    import seven_seg_scanner_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    // map each code to its pattern; out-of-range codes flag an invalid count
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed 4-digit common-anode driver; LEADING_ZERO_BLANK_EN blanks leading zeros
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input logic              clk,
    input logic              reset,
    seven_seg_scanner_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic [3:0]    snap_dp_q, snap_dp_d;
    logic          live_q, live_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          tick, frame_start, blank, show;
    logic [3:0]    nib;
    logic [6:0]    dec;
    assign nib = snap_d[idx_d*4 +: 4];
    bcd_to_7seg u_dec (.bcd(nib), .seg(dec));
`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] lz;
    // a slot is blanked when it and every digit to its left are zero, unless its dp is requested
    assign lz    = {snap_d[15:12] == 4'd0, snap_d[15:8] == 8'd0, snap_d[15:4] == 12'd0, 1'b0} & ~snap_dp_d;
    assign blank = lz[idx_d];
`else
    assign blank = 1'b0;
`endif
    // refresh counting, scan index, frame snapshot and next output values
    always_comb begin
        tick        = bus.en && (cnt_q == CW'(REFRESH_DIV - 1));
        frame_start = tick && (idx_q == 2'd3);
        cnt_d       = !bus.en ? cnt_q : (tick ? '0 : cnt_q + 1'b1);
        idx_d       = tick ? idx_q + 2'd1 : idx_q;
        snap_d      = frame_start ? bus.digits : snap_q;
        snap_dp_d   = frame_start ? bus.dp_in : snap_dp_q;
        live_d      = live_q || frame_start;
        show        = bus.en && live_d && !blank;
        an_d        = show ? an_sel(idx_d) : AN_OFF;
        seg_d       = show ? dec : SEG_OFF;
        dp_d        = show ? ~snap_dp_d[idx_d] : 1'b1;
    end
    // state and registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= 2'd3;
            snap_q    <= '0;
            snap_dp_q <= '0;
            live_q    <= 1'b0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            snap_dp_q <= snap_dp_d;
            live_q    <= live_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end
    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for the Basys3 4-digit common-anode seven-segment display. Consumes the 4-bit BCD digits produced by the clock's modulo-10/modulo-6 counter chain, snapshots them once per display frame, and drives one anode at a time with the decoded segment pattern. Sits at the output end of the clock datapath, directly downstream of the digit counters, and connects straight to top-level pins.

## Interface
- REFRESH_DIV, 100000: clk cycles per digit slot. 100 MHz gives 1 kHz per digit, 250 Hz per frame. Must be ≥ 2.
- clk  input  1  system clock, 100 MHz on board.
- reset  input  1  synchronous, active-high.
- en  input  1  scan enable. Low freezes the scan and blanks the display.
- digits  input  16  BCD digits. [3:0] is digit0 (rightmost) and [15:12] is digit3 (leftmost).
- dp_in  input  4  decimal-point request per digit, active-high. Bit i belongs to digit i.
- seg  output  7  segment cathodes, active-low. Bit order is {g,f,e,d,c,b,a}.
- dp  output  1  decimal-point cathode, active-low.
- an  output  4  digit anodes, active-low. an[i] enables digit i.

## Operation
- Refresh counter: counts 0..REFRESH_DIV-1 while en=1, then wraps to 0. A tick is asserted in the cycle where count == REFRESH_DIV-1 and en=1.
- Scan index (2 bits): advances by one on each tick and wraps 3→0.
- Frame snapshot: on a tick that wraps the index 3→0, digits and dp_in are copied into internal registers. Digits never change mid-frame, so there is no tearing.
- Decode, codes 0–9: standard patterns. Examples: 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
- Decode, codes 10–15: shown as a dash (g only, 7'b0111111) to flag an invalid count.
- Outputs are registered:
  - an = one-hot-low of index.
  - seg = decode(snapshot[index]).
  - dp = ~snap_dp[index].
- en=0:
  - Refresh counter and index hold.
  - an=4'b1111, seg=7'b1111111 and dp=1 from the next cycle.
  - Snapshot is retained.
  - When en returns to 1, counting resumes from the held count.
- Reset values:
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Refresh count=0, index=3.
  - Snapshot cleared to all zeros.

## Timing
- After reset is released, the display stays dark for REFRESH_DIV cycles.
- The first tick moves the index 3→0 and takes the snapshot. an=4'b1110 with digit0 appears on the cycle after the tick.
- Tick-to-output latency is 1 cycle, and an/seg/dp always change in the same cycle.
- A digit value change is visible no later than the next frame start, at most 4·REFRESH_DIV+1 cycles later.
- Reset asserted mid-frame takes effect at the next clk edge, overrides en, and restores every reset value listed above.
- en falling in the same cycle as a tick: the tick is suppressed and the index does not advance.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Evaluated on the snapshot.
  - Digit3 is blanked if it is 0.
  - Digit2 is blanked if it and digit3 are 0.
  - Digit1 is blanked if it, digit2 and digit3 are 0.
  - Digit0 is never blanked.
  - A blanked slot keeps its time slot but drives an=4'b1111 and dp=1.
  - A blanked digit with dp_in set is not blanked.
- LEADING_ZERO_BLANK_EN undefined: all four digits are always displayed, including leading zeros.

## Structure
- Shared package holds:
  - The segment pattern constants SEG_0..SEG_9, SEG_DASH and SEG_OFF.
  - The anode one-hot-low constants.
  - The default REFRESH_DIV.
- One sub-module, bcd_to_7seg: purely combinational, 4-bit in, 7-bit active-low out. It is reused by any future display block.
- The top of seven_seg_scanner holds:
  - The refresh counter.
  - The index.
  - The snapshot.
  - The blank logic.
  - The output registers.

## Test plan
All tests use REFRESH_DIV=4 unless stated.
- Reset release, digits=16'h1234: the display stays dark for 4 cycles. Then the sequence is:
  - an=1110, seg=7'b0011001 (4)
  - an=1101, 3
  - an=1011, 2
  - an=0111, 1
  - Each is held 4 cycles and the sequence repeats.
- Mid-frame change from digits=16'h0059 to 16'h0060 while index=1: the current frame still shows 5/9; the next frame shows 6/0.
- digits=16'h00A0: digit1 shows 7'b0111111 (dash). dp_in=4'b0100: dp=0 only while an=1011.
- en dropped for 10 cycles mid-slot: an=1111 and seg=7'b1111111 from the next cycle. When en returns, the same digit resumes and completes its remaining cycles.
- With LEADING_ZERO_BLANK_EN and digits=16'h0007:
  - an stays 1111 in the slots for digits 3–1.
  - Digit0 shows 7.
  - digits=16'h0000 shows only digit0 as 0.
- Reset pulse during index=2: next cycle all outputs are at their reset values and index=3. The first tick after that shows digit0.
